// File: rtl/sprite_rom_pkg.sv
// Shared types for the sprite ROM responder: FSM states, channel select, channel count.
package sprite_rom_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } resp_state_t;

   typedef logic chan_sel_t;

   localparam int unsigned NUM_CH = 2;

endpackage

// File: rtl/sprite_rom_chan.sv
// One requester channel: pending detect, ack toggle, data register and last-address hit entry.
module sprite_rom_chan
   import sprite_rom_pkg::*;
#(
   parameter int unsigned AW     = 16,
   parameter int unsigned DW     = 16,
   parameter bit          HIT_EN = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          req,
   input  logic [AW-1:0] addr,
   input  logic          ack_tgl,
   input  logic          fill,
   input  logic [DW-1:0] fill_q,
   input  logic [AW-1:0] fill_addr,
   output logic          ack,
   output logic [DW-1:0] q,
   output logic          pending,
   output logic          hit
);

   logic          ack_q;
   logic [DW-1:0] q_q;
   logic [AW-1:0] last_addr_q;
   logic          valid_q;

   // Ack toggles once per served request; data and hit entry load only on a memory fill.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_q       <= 1'b0;
         q_q         <= '0;
         last_addr_q <= '0;
         valid_q     <= 1'b0;
      end else begin
         if (ack_tgl) begin
            ack_q <= ~ack_q;
         end
         if (fill) begin
            q_q         <= fill_q;
            last_addr_q <= fill_addr;
         end
         // Flush wins over a completing fill so data fetched mid-download is never reused.
         if (flush) begin
            valid_q <= 1'b0;
         end else if (fill) begin
            valid_q <= 1'b1;
         end
      end
   end

   assign ack     = ack_q;
   assign q       = q_q;
   assign pending = req != ack_q;
   assign hit     = HIT_EN && valid_q && (addr == last_addr_q) && !flush;

endmodule

// File: rtl/sprite_rom_responder.sv
// Two-channel toggle req/ack ROM fetch responder sharing one memory read port.
module sprite_rom_responder
   import sprite_rom_pkg::*;
#(
   parameter int unsigned AW     = 16,
   parameter int unsigned DW     = 16,
   parameter bit          HIT_EN = 1'b1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  logic          ch0_req,
   input  logic [AW-1:0] ch0_addr,
   output logic          ch0_ack,
   output logic [DW-1:0] ch0_q,
   input  logic          ch1_req,
   input  logic [AW-1:0] ch1_addr,
   output logic          ch1_ack,
   output logic [DW-1:0] ch1_q,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ready,
   input  logic          mem_valid,
   input  logic [DW-1:0] mem_q,
   output logic          err
);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] ack_tgl;
   logic [NUM_CH-1:0] fill;

   resp_state_t   state_q;
   chan_sel_t     sel_q;
   chan_sel_t     rr_q;
   chan_sel_t     pick;
   logic          hit_q;
   logic          mem_rd_q;
   logic [AW-1:0] mem_addr_q;
   logic          err_q;

   sprite_rom_chan #(
      .AW     (AW),
      .DW     (DW),
      .HIT_EN (HIT_EN)
   ) u_chan0 (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .req       (ch0_req),
      .addr      (ch0_addr),
      .ack_tgl   (ack_tgl[0]),
      .fill      (fill[0]),
      .fill_q    (mem_q),
      .fill_addr (mem_addr_q),
      .ack       (ch0_ack),
      .q         (ch0_q),
      .pending   (pending[0]),
      .hit       (hit[0])
   );

   sprite_rom_chan #(
      .AW     (AW),
      .DW     (DW),
      .HIT_EN (HIT_EN)
   ) u_chan1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .req       (ch1_req),
      .addr      (ch1_addr),
      .ack_tgl   (ack_tgl[1]),
      .fill      (fill[1]),
      .fill_q    (mem_q),
      .fill_addr (mem_addr_q),
      .ack       (ch1_ack),
      .q         (ch1_q),
      .pending   (pending[1]),
      .hit       (hit[1])
   );

   // Arbitration: a lone pending channel wins; on contention the channel not served last wins.
   always_comb begin
      pick = pending[1];
      if (pending[0] && pending[1]) begin
         pick = ~rr_q;
      end
   end

   // Ack/fill strobes to the selected channel: delayed hit answer, or read data arriving in WAIT.
   always_comb begin
      ack_tgl = '0;
      fill    = '0;
      if (hit_q) begin
         ack_tgl[sel_q] = 1'b1;
      end
      if (state_q == WAIT && mem_valid) begin
         ack_tgl[sel_q] = 1'b1;
         fill[sel_q]    = 1'b1;
      end
   end

   // Service FSM, round-robin pointer, memory port registers and sticky error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         sel_q      <= 1'b0;
         rr_q       <= 1'b0;
         hit_q      <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         err_q      <= 1'b0;
      end else begin
         hit_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // The edge answering a hit does no arbitration, so the hit channel is not re-seen.
               if (hit_q) begin
                  rr_q <= sel_q;
               end else if (|pending) begin
                  sel_q <= pick;
                  if (hit[pick]) begin
                     hit_q <= 1'b1;
                  end else begin
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= pick ? ch1_addr : ch0_addr;
                     state_q    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  mem_rd_q <= 1'b0;
                  state_q  <= WAIT;
               end
            end
            WAIT: begin
               if (mem_valid) begin
                  rr_q    <= sel_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (mem_valid && state_q != WAIT) begin
            err_q <= 1'b1;
         end
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign err      = err_q;

endmodule

// File: tb/tb_sprite_rom_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_sprite_rom_responder;

   localparam bit HIT_EN = 1'b1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic [1:0]  req_v;
   logic [15:0] ch0_addr, ch1_addr;
   logic        ch0_ack, ch1_ack;
   logic [15:0] ch0_q, ch1_q;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic        mem_ready, mem_valid;
   logic [15:0] mem_q;
   logic        err;

   always #5 clk = ~clk;

   sprite_rom_responder #(
      .AW     (16),
      .DW     (16),
      .HIT_EN (HIT_EN)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .ch0_req   (req_v[0]),
      .ch0_addr  (ch0_addr),
      .ch0_ack   (ch0_ack),
      .ch0_q     (ch0_q),
      .ch1_req   (req_v[1]),
      .ch1_addr  (ch1_addr),
      .ch1_ack   (ch1_ack),
      .ch1_q     (ch1_q),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .mem_valid (mem_valid),
      .mem_q     (mem_q),
      .err       (err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Memory side controls and log of accepted read addresses.
   int          mem_lat    = 4;
   int          ready_hold = 0;
   bit          rand_ready = 1'b0;
   bit          spurious   = 1'b0;
   logic [15:0] rd_log[$];
   logic [15:0] acc_addr;

   // Reference model: per-channel last fetched address/valid and the last-served channel.
   logic [15:0] m_last [2];
   bit          m_valid[2];
   bit          m_rr;

   function automatic logic [15:0] mem_data(input logic [15:0] a);
      return a ^ 16'hACDB;
   endfunction

   function automatic logic get_ack(input int ch);
      return (ch == 1) ? ch1_ack : ch0_ack;
   endfunction

   function automatic logic [15:0] get_q(input int ch);
      return (ch == 1) ? ch1_q : ch0_q;
   endfunction

   function automatic bit model_hit(input int ch, input logic [15:0] a);
      return HIT_EN && m_valid[ch] && (m_last[ch] == a) && !flush;
   endfunction

   task automatic model_complete(input int ch, input logic [15:0] a, input bit h);
      if (!h) begin
         m_last[ch]  = a;
         m_valid[ch] = !flush;
      end
      m_rr = (ch == 1);
   endtask

   task automatic model_reset();
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
      m_last[0]  = '0;
      m_last[1]  = '0;
      m_rr       = 1'b0;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_addr(input int ch, input logic [15:0] a);
      if (ch == 1) ch1_addr = a;
      else ch0_addr = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for a channel's ack to catch up with its req; n = edges waited.
   task automatic wait_ack(input int ch, output int n);
      n = 0;
      while (get_ack(ch) != req_v[ch] && n < 400) begin
         tick();
         n++;
      end
      check_eq($sformatf("ack%0d_arrives", ch), 32'(get_ack(ch)), 32'(req_v[ch]));
   endtask

   task automatic req_one(input int ch, input logic [15:0] a);
      bit          h;
      int          n, nr, oc;
      logic        oa;
      logic [15:0] oq;
      oc = 1 - ch;
      h  = model_hit(ch, a);
      nr = rd_log.size();
      oa = get_ack(oc);
      oq = get_q(oc);
      set_addr(ch, a);
      req_v[ch] = ~req_v[ch];
      wait_ack(ch, n);
      check_eq($sformatf("q%0d@%h", ch, a), 32'(get_q(ch)), 32'(mem_data(a)));
      check_eq($sformatf("reads%0d@%h", ch, a), 32'(rd_log.size() - nr), h ? 32'd0 : 32'd1);
      if (h) begin
         check_eq("hit_latency", 32'(n), 32'd2);
      end else begin
         check_eq("miss_addr", 32'(rd_log[$]), 32'(a));
         check_eq("miss_latency_min", 32'(n >= 3), 32'd1);
      end
      check_eq("other_ack_stable", 32'(get_ack(oc)), 32'(oa));
      check_eq("other_q_stable", 32'(get_q(oc)), 32'(oq));
      model_complete(ch, a, h);
   endtask

   task automatic req_two(input logic [15:0] a0, input logic [15:0] a1);
      int          first, second, n, nr, exp_reads;
      logic [15:0] a_f, a_s;
      bit          h_f, h_s;
      first  = m_rr ? 0 : 1;
      second = 1 - first;
      a_f    = (first == 1) ? a1 : a0;
      a_s    = (first == 1) ? a0 : a1;
      nr     = rd_log.size();
      ch0_addr = a0;
      ch1_addr = a1;
      req_v    = ~req_v;
      n = 0;
      while (get_ack(0) != req_v[0] && get_ack(1) != req_v[1] && n < 400) begin
         tick();
         n++;
      end
      check_eq($sformatf("rr_first_ch%0d", first), 32'(get_ack(first) == req_v[first]), 32'd1);
      check_eq("rr_second_waits", 32'(get_ack(second) != req_v[second]), 32'd1);
      h_f = model_hit(first, a_f);
      model_complete(first, a_f, h_f);
      h_s = model_hit(second, a_s);
      wait_ack(second, n);
      model_complete(second, a_s, h_s);
      exp_reads = (h_f ? 0 : 1) + (h_s ? 0 : 1);
      check_eq("pair_q0", 32'(ch0_q), 32'(mem_data(a0)));
      check_eq("pair_q1", 32'(ch1_q), 32'(mem_data(a1)));
      check_eq("pair_reads", 32'(rd_log.size() - nr), 32'(exp_reads));
   endtask

   // Memory port model: accepts on mem_rd & mem_ready, answers after mem_lat extra cycles.
   initial begin : mem_side
      int   cnt;
      logic acc;
      cnt       = 0;
      acc       = 1'b0;
      acc_addr  = '0;
      mem_valid = 1'b0;
      mem_ready = 1'b0;
      mem_q     = '0;
      forever begin
         tick();
         mem_valid = 1'b0;
         if (acc) begin
            rd_log.push_back(acc_addr);
            cnt = mem_lat + 1;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               mem_valid = 1'b1;
               mem_q     = mem_data(rd_log[$]);
            end
         end else if (spurious) begin
            mem_valid = 1'b1;
            mem_q     = 16'hDEAD;
            spurious  = 1'b0;
         end
         if (ready_hold > 0) begin
            mem_ready = 1'b0;
            ready_hold--;
         end else begin
            mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         acc      = mem_rd & mem_ready;
         acc_addr = mem_addr;
      end
   end

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int          n;
      bit          ok;
      logic        oa0, oa1;
      logic [15:0] oq0, oq1, a, b;

      reset_n  = 1'b0;
      flush    = 1'b0;
      req_v    = '0;
      ch0_addr = '0;
      ch1_addr = '0;
      model_reset();
      repeat (3) tick();
      check_eq("rst_ack0", 32'(ch0_ack), 32'd0);
      check_eq("rst_ack1", 32'(ch1_ack), 32'd0);
      check_eq("rst_q0", 32'(ch0_q), 32'd0);
      check_eq("rst_q1", 32'(ch1_q), 32'd0);
      check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
      check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      reset_n = 1'b1;
      repeat (2) tick();

      // Single miss, then a repeat that must hit.
      mem_lat = 4;
      req_one(0, 16'h1234);
      check_eq("single_miss_q", 32'(ch0_q), 32'h0000BEEF);
      req_one(0, 16'h1234);

      // Contention, twice.
      mem_lat = 1;
      req_two(16'h2000, 16'h3000);
      req_two(16'h2100, 16'h3100);

      // Backpressure: memory refuses the read for a long stretch.
      ready_hold = 12;
      a   = 16'h7700;
      oa0 = ch0_ack;
      ch0_addr = a;
      req_v[0] = ~req_v[0];
      tick();
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ok &= mem_rd && (mem_addr == a) && (ch0_ack == oa0);
         tick();
      end
      check_eq("bp_stable", 32'(ok), 32'd1);
      wait_ack(0, n);
      check_eq("bp_q", 32'(ch0_q), 32'(mem_data(a)));
      model_complete(0, a, 1'b0);

      // Flush during a fetch prevents the refetch from hitting.
      flush = 1'b1;
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
      req_one(1, 16'h0040);
      flush = 1'b0;
      tick();
      req_one(1, 16'h0040);
      req_one(1, 16'h0040);

      // Randomized traffic with random latency and ready behaviour.
      for (int it = 0; it < 80; it++) begin
         mem_lat    = $urandom_range(0, 5);
         rand_ready = 1'($urandom_range(0, 1));
         a = 16'h0A00 + 16'($urandom_range(0, 3));
         b = 16'h0B00 + 16'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0:       req_one(0, a);
            1:       req_one(1, b);
            default: req_two(a, b);
         endcase
         if ($urandom_range(0, 9) == 0) begin
            flush = 1'b1;
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
            tick();
            flush = 1'b0;
         end
      end
      rand_ready = 1'b0;
      check_eq("no_err_clean_traffic", 32'(err), 32'd0);

      // Stray mem_valid in IDLE sets err and leaves channels untouched.
      repeat (3) tick();
      oa0 = ch0_ack;
      oa1 = ch1_ack;
      oq0 = ch0_q;
      oq1 = ch1_q;
      spurious = 1'b1;
      repeat (4) tick();
      check_eq("stray_err", 32'(err), 32'd1);
      check_eq("stray_ack0", 32'(ch0_ack), 32'(oa0));
      check_eq("stray_ack1", 32'(ch1_ack), 32'(oa1));
      check_eq("stray_q0", 32'(ch0_q), 32'(oq0));
      check_eq("stray_q1", 32'(ch1_q), 32'(oq1));

      // Asynchronous reset while waiting on memory; the late read data is flagged.
      mem_lat  = 30;
      ch1_addr = 16'h5555;
      req_v[1] = ~req_v[1];
      repeat (6) tick();
      #2;
      reset_n = 1'b0;
      req_v   = '0;
      #1;
      check_eq("arst_ack0", 32'(ch0_ack), 32'd0);
      check_eq("arst_ack1", 32'(ch1_ack), 32'd0);
      check_eq("arst_q0", 32'(ch0_q), 32'd0);
      check_eq("arst_q1", 32'(ch1_q), 32'd0);
      check_eq("arst_mem_rd", 32'(mem_rd), 32'd0);
      check_eq("arst_err", 32'(err), 32'd0);
      model_reset();
      tick();
      reset_n = 1'b1;
      repeat (40) tick();
      check_eq("late_valid_err", 32'(err), 32'd1);
      check_eq("late_valid_no_ack1", 32'(ch1_ack), 32'd0);
      mem_lat = 2;
      req_one(0, 16'h1234);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
